// File: rtl/uart_frame_decoder.sv
// Sync-hunting, length-prefixed UART frame decoder with buffered, validated payload stream.
// Optional checksum byte and check enabled by defining UART_FRAME_CSUM_EN.
module uart_frame_decoder #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int W  = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = $clog2(TIMEOUT_CLKS) + 1;

  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    MAX_L   = 9'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [1:0] E_LEN     = 2'd0;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_OVERRUN = 2'd3;

`ifdef UART_FRAME_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [1:0] E_CSUM = 2'd1;
  logic [7:0] sum_q, sum_d;
`endif

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [W-1:0]  wr_q, wr_d;
  logic [W-1:0]  rd_q, rd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic       buf_we;
  logic [7:0] buf_mem [2**AW];

  logic busy;
  logic timeout;
  logic wr_last;
  logic rd_last;

  assign busy    = (state_q == S_LEN) || (state_q == S_PAYLOAD)
`ifdef UART_FRAME_CSUM_EN
                || (state_q == S_CSUM)
`endif
                ;
  assign timeout = busy && !in_valid && (gap_q == GAP_MAX);
  assign wr_last = (9'(wr_q) + 9'd1) == {1'b0, len_q};
  assign rd_last = (9'(rd_q) + 9'd1) == {1'b0, len_q};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    gap_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    sum_d       = sum_q;
`endif

    if (busy && !in_valid) gap_d = gap_q + GW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (in_valid) begin
          if (in_data == 8'd0 || {1'b0, in_data} > MAX_L) begin
            frame_err_d = 1'b1;
            err_code_d  = E_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = in_data;
            wr_d    = '0;
            state_d = S_PAYLOAD;
`ifdef UART_FRAME_CSUM_EN
            sum_d   = in_data;
`endif
          end
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          wr_d   = wr_q + W'(1);
`ifdef UART_FRAME_CSUM_EN
          sum_d  = sum_q + in_data;
          if (wr_last) state_d = S_CSUM;
`else
          if (wr_last) begin
            frame_ok_d = 1'b1;
            rd_d       = '0;
            state_d    = S_DRAIN;
          end
`endif
        end
      end
`ifdef UART_FRAME_CSUM_EN
      S_CSUM: begin
        if (in_valid) begin
          if (sum_q + in_data == 8'd0) begin
            frame_ok_d = 1'b1;
            rd_d       = '0;
            state_d    = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = E_CSUM;
            state_d     = S_IDLE;
          end
        end
      end
`endif
      S_DRAIN: begin
        // a byte arriving mid-drain is lost; draining carries on
        if (in_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = E_OVERRUN;
        end
        if (out_ready) begin
          rd_d = rd_q + W'(1);
          if (rd_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = E_TIMEOUT;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      gap_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
`ifdef UART_FRAME_CSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      gap_q       <= gap_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
`ifdef UART_FRAME_CSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_q[AW-1:0]] <= in_data;
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = out_valid ? buf_mem[rd_q[AW-1:0]] : 8'h00;
  assign out_last  = out_valid && rd_last;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; follows UART_FRAME_CSUM_EN
// to decide whether frames carry a checksum byte.
module tb_uart_frame_decoder;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  int ok_cnt = 0;
  int err_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rx_q [$];
  bit         lst_q [$];
  logic [7:0] pl [$];

  uart_frame_decoder #(
    .MAX_LEN(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        lst_q.push_back(out_last);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_sb();
    ok_cnt  = 0;
    err_cnt = 0;
    ov_cnt  = 0;
    rx_q.delete();
    lst_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] csum_adj);
    logic [7:0] s;
    s = 8'(pl.size());
    send_byte(8'hA5);
    send_byte(8'(pl.size()));
    foreach (pl[i]) begin
      send_byte(pl[i]);
      s = s + pl[i];
    end
`ifdef UART_FRAME_CSUM_EN
    send_byte(8'(8'h00 - s) + csum_adj);
`else
    s = s + csum_adj;
`endif
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 200 && rx_q.size() < n; i++) tick(1);
    tick(2);
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] lv;
    logic [31:0] lx;
    check({tag, "_cnt"}, rx_q.size(), pl.size());
    lv = '0;
    lx = '0;
    foreach (pl[i]) begin
      check({tag, "_dat"}, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hdead,
            {24'h0, pl[i]});
      if (i < lst_q.size() && lst_q[i]) lv[i] = 1'b1;
    end
    lx[pl.size()-1] = 1'b1;
    check({tag, "_last"}, lv, lx);
  endtask

  initial begin
    int n;

    tick(3);
    check("rst_ov", out_valid, 1'b0);
    check("rst_ol", out_last, 1'b0);
    check("rst_ok", frame_ok, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_od", out_data, 8'h00);
    check("rst_ec", err_code, 2'd0);
    rst = 1'b0;
    tick(2);

    // good 3-byte frame
    clear_sb();
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00);
    check("t1_ok_now", frame_ok, 1'b1);
    check("t1_ov_now", out_valid, 1'b1);
    check("t1_od_now", out_data, 8'h11);
    wait_out(3);
    check_rx("t1");
    check("t1_okcnt", ok_cnt, 1);
    check("t1_errcnt", err_cnt, 0);

`ifdef UART_FRAME_CSUM_EN
    clear_sb();
    send_frame(8'h01);
    tick(3);
    check("t2_errcnt", err_cnt, 1);
    check("t2_code", err_code, 2'd1);
    check("t2_ov", ov_cnt, 0);
    clear_sb();
    send_frame(8'h00);
    wait_out(3);
    check_rx("t2b");
    check("t2b_errcnt", err_cnt, 0);
`endif

    // single-byte frame
    clear_sb();
    pl = '{8'h7E};
    send_frame(8'h00);
    wait_out(1);
    check_rx("t1b");
    check("t1b_okcnt", ok_cnt, 1);

    // length errors, then stray bytes ignored
    clear_sb();
    send_byte(8'hA5);
    send_byte(8'h00);
    tick(2);
    check("t3_code0", err_code, 2'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    tick(TO + 10);
    check("t3_errcnt", err_cnt, 2);
    check("t3_code", err_code, 2'd0);
    check("t3_ov", ov_cnt, 0);
    check("t3_okcnt", ok_cnt, 0);

    // maximum length accepted
    clear_sb();
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'hC0 + i));
    send_frame(8'h00);
    wait_out(16);
    check_rx("tmax");
    check("tmax_err", err_cnt, 0);

    // backpressure with overrun
    clear_sb();
    pl = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b0;
    send_frame(8'h00);
    tick(10);
    send_byte(8'hA5);
    tick(38);
    check("t4_errcnt", err_cnt, 1);
    check("t4_code", err_code, 2'd3);
    check("t4_od", out_data, 8'h11);
    check("t4_ol", out_last, 1'b0);
    check("t4_ov", out_valid, 1'b1);
    check("t4_rx", rx_q.size(), 0);
    out_ready = 1'b1;
    wait_out(3);
    check_rx("t4");
    check("t4_okcnt", ok_cnt, 1);

    // timeout counted from the edge that samples 11
    clear_sb();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    n = 0;
    while (n < 4 * TO && !frame_err) begin
      tick(1);
      n++;
    end
    check("t5_gap", n, TO);
    check("t5_code", err_code, 2'd2);
    check("t5_ov", ov_cnt, 0);
    clear_sb();
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00);
    wait_out(3);
    check_rx("t5b");

    // byte arriving on the timeout cycle wins
    clear_sb();
    pl = '{8'h11, 8'h22};
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    tick(TO - 2);
    send_byte(8'h22);
`ifdef UART_FRAME_CSUM_EN
    send_byte(8'hCB);
`endif
    wait_out(2);
    check_rx("t5c");
    check("t5c_err", err_cnt, 0);

    // noise before a frame
    clear_sb();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00);
    wait_out(3);
    check_rx("t6");
    check("t6_err", err_cnt, 0);

    // reset mid-frame
    clear_sb();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6r_ov", out_valid, 1'b0);
    check("t6r_fe", frame_err, 1'b0);
    check("t6r_ec", err_code, 2'd0);
    tick(TO + 10);
    check("t6r_err", err_cnt, 0);
    check("t6r_ovc", ov_cnt, 0);
    clear_sb();
    send_frame(8'h00);
    wait_out(3);
    check_rx("t6b");
    check("t6b_ok", ok_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-stream framer sitting directly downstream of the UART receiver. It consumes one-cycle `in_valid` byte pulses, hunts for a sync byte, and parses a length-prefixed, checksummed frame. The payload is held in an internal buffer and released as a valid/ready stream only after the whole frame has been validated. Malformed, truncated, or overrunning frames are dropped and reported with an error pulse and code.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes; sets buffer depth (1..255).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, default 21700: idle clocks allowed between bytes inside a frame (≈10 byte times at 217 clks/bit).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high; clock clk.
- `in_data` in 8: received byte; meaningful only while `in_valid` is high.
- `in_valid` in 1: one-cycle strobe per received byte.
- `out_data` out 8: payload byte.
- `out_valid` out 1: payload byte available.
- `out_ready` in 1: downstream accepts byte.
- `out_last` out 1: high with the final payload byte.
- `frame_ok` out 1: one-cycle pulse when a frame passes validation.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.
- `err_code` out 2: cause of last error; 0 = LEN, 1 = CSUM, 2 = TIMEOUT, 3 = OVERRUN. Held until the next error.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN. Reset goes to IDLE.
- IDLE: an `in_valid` byte equal to `SYNC_BYTE` moves to LEN. All other bytes are silently ignored.
- LEN: the next byte is the length L.
  - If L == 0 or L > `MAX_LEN`: error LEN, go to IDLE.
  - Otherwise latch L, clear the write index and sum, go to PAYLOAD.
  - The running sum starts at L.
- PAYLOAD: each byte is written to `buf[wr]`, then `wr++` and `sum += byte` (mod 256). After the L-th byte, go to CSUM.
- CSUM: the received byte C is valid if (sum + C) mod 256 == 0.
  - Valid: pulse `frame_ok`, set `rd` = 0, go to DRAIN.
  - Invalid: error CSUM, go to IDLE.
- DRAIN:
  - `out_valid` = 1 and `out_data` = `buf[rd]`.
  - `out_last` = (`rd` == L-1).
  - On `out_valid && out_ready`: `rd++`. The transfer with `out_last` high returns to IDLE.
  - `out_data` and `out_last` stay stable while `out_ready` is low.
- Timeout: in LEN, PAYLOAD, or CSUM, a gap counter increments every clock and clears on `in_valid`. Reaching `TIMEOUT_CLKS`-1 raises error TIMEOUT and goes to IDLE. The counter is idle in IDLE and DRAIN.
- Overrun: any `in_valid` during DRAIN drops that byte and raises error OVERRUN. Draining continues unaffected. Sync hunting resumes only after DRAIN ends.
- An error sets `frame_err` for one cycle and updates `err_code`. The buffer contents are never presented after an error.

## Timing
- Reset values: `out_valid`, `out_last`, `frame_ok`, and `frame_err` are 0; `out_data` and `err_code` are 0. State is IDLE and all counters are 0.
- All outputs are registered or decoded from registered state; there are no combinational paths from `in_*` to `out_*`.
- `frame_ok` and the first `out_valid` rise on the cycle after the clock edge that samples the checksum byte.
- `frame_err` rises on the cycle after the offending byte is sampled, or after the timeout count is reached.
- Throughput: one payload byte per clock when `out_ready` is held high. A frame of L bytes drains in L cycles.
- `in_valid` and a timeout on the same cycle: the byte wins. It is processed and the counter clears.
- `rst` mid-frame or mid-drain: next cycle is IDLE with outputs at reset values. A partial frame is discarded without a `frame_err`.
- Widths:
  - Gap counter is `$clog2(TIMEOUT_CLKS)+1` bits.
  - `wr` and `rd` are `$clog2(MAX_LEN)+1` bits.
  - Length and sum are 8 bits, wrapping.

## Configuration
- `UART_FRAME_CSUM_EN` defined: CSUM state and checksum check are present, as described above.
- Not defined: no checksum byte is expected. After the L-th payload byte the block goes directly to DRAIN with a `frame_ok` pulse. `err_code` 1 is never produced, and the sum logic is removed.

## Test plan
1. Good frame: A5 03 11 22 33 97 → `frame_ok` once; `out_data` 11, 22, 33; `out_last` only on 33; no `frame_err`.
2. Bad checksum: A5 03 11 22 33 98 → `frame_err` with `err_code`=1; `out_valid` never asserts; a following good frame is decoded correctly.
3. Length errors: A5 00, then A5 11 (17 > `MAX_LEN`) → two `frame_err` pulses with `err_code`=0; remaining bytes are ignored until the next A5.
4. Backpressure and overrun: good frame with `out_ready` low for 50 cycles; send byte A5 during DRAIN → `err_code`=3; `out_data` holds 11; after `out_ready` goes high, 11, 22, 33 drain intact.
5. Timeout: A5 02 11, then no `in_valid` → `frame_err` with `err_code`=2 exactly `TIMEOUT_CLKS` cycles after byte 11 is sampled; the next good frame passes.
6. Noise and reset: 00 FF 5A before a good frame → ignored, frame decoded. `rst` pulsed after the second payload byte → IDLE with no error and no output; the next frame decodes.
